// File: rtl/cmp_pkg.sv
// Shared constants for the serial magnitude comparator.
// State encoding and result-vector bit positions.
package cmp_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPARE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam int RES_GT = 2;
    localparam int RES_EQ = 1;
    localparam int RES_LT = 0;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        COMPARE = ST_COMPARE,
        DONE    = ST_DONE
    } state_t;

endpackage

// File: rtl/comparator_2bit.sv
// Combinational 2-bit magnitude comparator slice.
// Compares {A1,A0} with {B1,B0}; exactly one output is high.
module comparator_2bit (
    input  logic A1,
    input  logic A0,
    input  logic B1,
    input  logic B0,
    output logic A_gt_B,
    output logic A_eq_B,
    output logic A_lt_B
);

    logic hi_eq;

    assign hi_eq  = ~(A1 ^ B1);
    assign A_gt_B = (A1 & ~B1) | (hi_eq & A0 & ~B0);
    assign A_lt_B = (~A1 & B1) | (hi_eq & ~A0 & B0);
    assign A_eq_B = hi_eq & ~(A0 ^ B0);

endmodule

// File: rtl/serial_mag_comparator.sv
// Digit-serial magnitude comparator, MSB digit first, early exit
// on the first unequal digit.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter  int WIDTH  = 8,
    localparam int DIGITS = WIDTH / 2,
    localparam int CW     = $clog2(DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CW-1:0]    digits_used
);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;
    logic [2:0]       res;
    logic             s_gt;
    logic             s_eq;
    logic             s_lt;
    logic             last;

    comparator_2bit u_slice (
        .A1     (a_sr[WIDTH-1]),
        .A0     (a_sr[WIDTH-2]),
        .B1     (b_sr[WIDTH-1]),
        .B0     (b_sr[WIDTH-2]),
        .A_gt_B (s_gt),
        .A_eq_B (s_eq),
        .A_lt_B (s_lt)
    );

    assign last        = (cnt == CW'(DIGITS - 1));
    assign start_ready = (state == IDLE) && !rst;
    assign gt          = res[RES_GT];
    assign eq          = res[RES_EQ];
    assign lt          = res[RES_LT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start_valid) state_n = COMPARE;
            COMPARE: if (!s_eq || last) state_n = DONE;
            DONE:    if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr        <= '0;
            b_sr        <= '0;
            cnt         <= '0;
            res         <= '0;
            digits_used <= '0;
            res_valid   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        a_sr <= a_in;
                        b_sr <= b_in;
                        cnt  <= '0;
                    end
                end
                COMPARE: begin
                    cnt <= cnt + 1'b1;
                    if (!s_eq) begin
                        res[RES_GT] <= s_gt;
                        res[RES_LT] <= s_lt;
                        digits_used <= cnt + 1'b1;
                        res_valid   <= 1'b1;
                    end else if (last) begin
                        res[RES_EQ] <= 1'b1;
                        digits_used <= CW'(DIGITS);
                        res_valid   <= 1'b1;
                    end else begin
                        a_sr <= a_sr << 2;
                        b_sr <= b_sr << 2;
                    end
                end
                DONE: begin
                    // digits_used is left alone so it stays readable after the handshake
                    if (res_ready) begin
                        res       <= '0;
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: directed cases at WIDTH=8, exhaustive
// plus random back-pressure at WIDTH=4, against a bit-position reference.
module tb_serial_mag_comparator;

    logic       clk;
    logic       rst;

    logic       sv8, srdy8, rv8, rr8, gt8, eq8, lt8;
    logic [7:0] a8, b8;
    logic [2:0] du8;

    logic       sv4, srdy4, rv4, rr4, gt4, eq4, lt4;
    logic [3:0] a4, b4;
    logic [1:0] du4;

    int n_cmp = 0;
    int n_err = 0;

    serial_mag_comparator #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst),
        .start_valid(sv8), .start_ready(srdy8),
        .a_in(a8), .b_in(b8),
        .res_valid(rv8), .res_ready(rr8),
        .gt(gt8), .eq(eq8), .lt(lt8),
        .digits_used(du8)
    );

    serial_mag_comparator #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst),
        .start_valid(sv4), .start_ready(srdy4),
        .a_in(a4), .b_in(b4),
        .res_valid(rv4), .res_ready(rr4),
        .gt(gt4), .eq(eq4), .lt(lt4),
        .digits_used(du4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // The decision digit is the one holding the highest differing bit.
    function automatic void model(input int w, input int a, input int b,
                                  output logic [2:0] f, output int used);
        int x;
        int p;
        x = a ^ b;
        p = 0;
        if (x == 0) begin
            f    = 3'b010;
            used = w / 2;
        end else begin
            for (int i = 0; i < w; i++) if (x[i]) p = i;
            used = w / 2 - p / 2;
            f    = (a > b) ? 3'b100 : 3'b001;
        end
    endfunction

    task automatic txn8(input logic [7:0] a, input logic [7:0] b,
                        input int hold, input string tag);
        logic [2:0] ef;
        int         eu;
        int         lat;
        model(8, a, b, ef, eu);
        n_cmp++;
        if (srdy8 !== 1'b1) begin
            n_err++;
            $display("FAIL %s start_ready got %b want 1", tag, srdy8);
        end
        sv8 = 1'b1; a8 = a; b8 = b; rr8 = (hold == 0);
        @(posedge clk); #1;
        sv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (rv8 !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat !== eu) begin
            n_err++;
            $display("FAIL %s latency got %0d want %0d", tag, lat, eu);
        end
        n_cmp++;
        if ({gt8, eq8, lt8} !== ef) begin
            n_err++;
            $display("FAIL %s flags a=%h b=%h got %b want %b", tag, a, b, {gt8, eq8, lt8}, ef);
        end
        n_cmp++;
        if (du8 !== 3'(eu)) begin
            n_err++;
            $display("FAIL %s digits_used got %0d want %0d", tag, du8, eu);
        end
        for (int i = 0; i < hold; i++) begin
            sv8 = (i == 1);
            @(posedge clk); #1;
            n_cmp++;
            if (rv8 !== 1'b1 || {gt8, eq8, lt8} !== ef || du8 !== 3'(eu) || srdy8 !== 1'b0) begin
                n_err++;
                $display("FAIL %s hold%0d got rv=%b f=%b du=%0d srdy=%b want rv=1 f=%b du=%0d srdy=0",
                         tag, i, rv8, {gt8, eq8, lt8}, du8, srdy8, ef, eu);
            end
        end
        sv8 = 1'b0; rr8 = 1'b1;
        @(posedge clk); #1;
        rr8 = 1'b0;
        n_cmp++;
        if (rv8 !== 1'b0 || {gt8, eq8, lt8} !== 3'b000 || srdy8 !== 1'b1 || du8 !== 3'(eu)) begin
            n_err++;
            $display("FAIL %s release got rv=%b f=%b srdy=%b du=%0d want rv=0 f=000 srdy=1 du=%0d",
                     tag, rv8, {gt8, eq8, lt8}, srdy8, du8, eu);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({rv8, gt8, eq8, lt8, du8, srdy8} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_hold got rv=%b f=%b du=%0d srdy=%b want all 0",
                     rv8, {gt8, eq8, lt8}, du8, srdy8);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (srdy8 !== 1'b1 || srdy4 !== 1'b1 || rv4 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release got srdy8=%b srdy4=%b rv4=%b want 1 1 0", srdy8, srdy4, rv4);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        txn8(8'hB4, 8'h74, 0, "b4_74");
        txn8(8'h5A, 8'h5A, 0, "5a_5a");
        txn8(8'h12, 8'h13, 0, "12_13");
        txn8(8'h00, 8'hC0, 0, "00_c0");
        txn8(8'h00, 8'h00, 1, "zeros");
        txn8(8'hFF, 8'hFF, 2, "ones");
        txn8(8'h31, 8'h30, 5, "31_30_hold");
    endtask

    task automatic test_reset_mid;
        logic seen;
        sv8 = 1'b1; a8 = 8'h00; b8 = 8'h01; rr8 = 1'b1;
        @(posedge clk); #1;
        sv8 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({rv8, gt8, eq8, lt8, du8, srdy8} !== 9'b0) begin
            n_err++;
            $display("FAIL midreset got rv=%b f=%b du=%0d srdy=%b want all 0",
                     rv8, {gt8, eq8, lt8}, du8, srdy8);
        end
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen |= rv8;
        end
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen |= rv8;
        end
        rr8 = 1'b0;
        n_cmp++;
        if (seen !== 1'b0 || srdy8 !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_after got seen_rv=%b srdy=%b want 0 1", seen, srdy8);
        end
        txn8(8'hFF, 8'hFE, 0, "ff_fe");
    endtask

    task automatic test_random8;
        for (int i = 0; i < 40; i++)
            txn8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), "rand8");
        txn8(8'h47, 8'h45, 0, "b2b_a");
        txn8(8'h47, 8'h4B, 0, "b2b_b");
    endtask

    task automatic test_sweep4;
        logic [2:0] ef;
        int         eu;
        int         lat;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                model(4, a, b, ef, eu);
                n_cmp++;
                if (srdy4 !== 1'b1) begin
                    n_err++;
                    $display("FAIL sweep4 start_ready a=%0d b=%0d got %b want 1", a, b, srdy4);
                end
                sv4 = 1'b1; a4 = 4'(a); b4 = 4'(b); rr4 = 1'($urandom);
                @(posedge clk); #1;
                sv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
                lat = 0;
                while (rv4 !== 1'b1 && lat < 8) begin
                    rr4 = 1'($urandom);
                    @(posedge clk); #1;
                    lat++;
                end
                n_cmp++;
                if (lat !== eu || {gt4, eq4, lt4} !== ef || du4 !== 2'(eu)
                    || (gt4 + eq4 + lt4) !== 2'd1) begin
                    n_err++;
                    $display("FAIL sweep4 a=%0d b=%0d got lat=%0d f=%b du=%0d want lat=%0d f=%b du=%0d",
                             a, b, lat, {gt4, eq4, lt4}, du4, eu, ef, eu);
                end
                rr4 = 1'($urandom);
                while (rr4 !== 1'b1) begin
                    @(posedge clk); #1;
                    n_cmp++;
                    if (rv4 !== 1'b1 || {gt4, eq4, lt4} !== ef) begin
                        n_err++;
                        $display("FAIL sweep4_stall a=%0d b=%0d got rv=%b f=%b want rv=1 f=%b",
                                 a, b, rv4, {gt4, eq4, lt4}, ef);
                    end
                    rr4 = 1'($urandom);
                end
                @(posedge clk); #1;
                rr4 = 1'b0;
                n_cmp++;
                if (rv4 !== 1'b0 || {gt4, eq4, lt4} !== 3'b000) begin
                    n_err++;
                    $display("FAIL sweep4_clear a=%0d b=%0d got rv=%b f=%b want 0 000",
                             a, b, rv4, {gt4, eq4, lt4});
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        sv8 = 1'b0; a8 = '0; b8 = '0; rr8 = 1'b0;
        sv4 = 1'b0; a4 = '0; b4 = '0; rr4 = 1'b0;
        test_reset();
        test_directed();
        test_reset_mid();
        test_random8();
        test_sweep4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
